alu_result_buffer: RTL and testbench
====================================

Name: alu_result_buffer

Overview:
- Registered output stage directly downstream of the combinational ALU units, such as the set-less-than unit.
- Accepts one 32-bit result plus its zero flag per handshake and buffers it in a DEPTH-entry FIFO.
- Presents results to the writeback/consumer side through a valid/ready interface.
- Also derives a negative flag, checks zero-flag consistency, and keeps saturating retirement statistics.

Parameters:
- WIDTH, 32, result datapath width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream ALU result valid.
- in_ready  out  1  buffer can accept an entry this cycle.
- in_result  in  WIDTH  ALU result word.
- in_zero  in  1  upstream zero flag (1 when result is zero).
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts the head entry.
- out_result  out  WIDTH  head result.
- out_zero  out  1  head zero flag.
- out_neg  out  1  head negative flag.
- fill  out  $clog2(DEPTH+1)  number of occupied entries.
- stat_clr  in  1  synchronous clear of statistics and error flag.
- stat_total  out  CNT_W  number of results retired.
- stat_zero  out  CNT_W  number of retired results with zero flag set.
- err_flag  out  1  sticky zero-flag inconsistency.

Behaviour:
- Reset (rst_n low, asynchronous): the following all go to 0 immediately and hold while rst_n is low.
  - read/write pointers, fill, out_valid, out_result, out_zero, out_neg
  - stat_total, stat_zero, err_flag
- in_ready = (fill != DEPTH). It is purely a function of state, with no combinational path from out_ready. It is therefore 1 during and after reset.
- Push = in_valid & in_ready.
  - Stores {in_result, in_zero, neg = in_result[WIDTH-1]} at the write pointer.
  - The write pointer wraps modulo DEPTH.
- Pop = out_valid & out_ready.
  - Advances the read pointer, which wraps modulo DEPTH.
- Status signals:
  - out_valid = (fill != 0).
  - out_result, out_zero and out_neg show the head entry and are forced to 0 when out_valid = 0.
- Latency: a push into an empty buffer shows out_valid = 1 on the next cycle. There is no same-cycle bypass.
- Push and pop in the same cycle: fill is unchanged and both pointers advance. This is legal when full, but in_ready is 0 when full, so a push cannot occur then.
- Full: in_valid is ignored; the upstream must hold its data.
- Empty: out_ready is ignored, and no counter changes.
- Consistency check on each push: if in_zero != (in_result == 0), err_flag is set and stays 1 until stat_clr or reset. The entry is still stored as given.
- Statistics on each pop:
  - stat_total increments by 1.
  - stat_zero increments by 1 if the head's zero flag is 1.
  - Both counters saturate at 2^CNT_W - 1 and do not wrap.
- stat_clr: stat_total, stat_zero and err_flag become 0 on the next edge.
  - stat_clr has priority over a same-cycle pop or error; that pop is not counted.
  - stat_clr does not affect FIFO contents.
- Reset mid-operation: all buffered entries are discarded and no partial state survives.

Decomposition:
- Shared package alu_pkg holds:
  - the ALU_WIDTH constant (32)
  - a result-entry struct {result, zero, neg}
  - the all-ones/zero result constants used by the compare units.
- One sub-module, sat_counter (parameterised width, inc, clr, asynchronous active-low reset), instantiated twice for stat_total and stat_zero.

Test Plan:
- Reset release, then push in_result = 0xFFFFFFFF, in_zero = 0 with out_ready = 0 → next cycle out_valid = 1, out_result = 0xFFFFFFFF, out_neg = 1, fill = 1, err_flag = 0.
- Push 4 entries (0x1, 0x0/zero = 1, 0x80000000, 0x7) with out_ready = 0 → fill = 4, in_ready = 0. A fifth in_valid is ignored. Then drain with out_ready = 1 → order 0x1, 0x0, 0x80000000, 0x7; stat_total = 4, stat_zero = 1.
- Steady stream with in_valid = out_ready = 1 for 10 cycles → fill stays 1 after the first cycle, pointers wrap twice, stat_total = 9 at the end, and no data is reordered.
- Push in_result = 0x0 with in_zero = 0 → err_flag = 1 and stays 1. Then stat_clr = 1 for one cycle together with a pop → err_flag = 0, stat_total = 0.
- With CNT_W = 2, retire 5 results → stat_total saturates at 3.
- With 3 entries buffered, pulse rst_n low mid-cycle → out_valid, fill and the stat counters drop to 0 asynchronously; in_ready = 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the compare units and the result buffer.
//   ALU_WIDTH   : native ALU datapath width
//   alu_entry_t : one buffered result {result, zero, neg}
//   ALU_ZERO / ALU_ONES : all-zeros / all-ones result words
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] result;
    logic                 zero;
    logic                 neg;
  } alu_entry_t;

  localparam logic [ALU_WIDTH-1:0] ALU_ZERO = '0;
  localparam logic [ALU_WIDTH-1:0] ALU_ONES = '1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : increment by one (ignored once count is all ones)
//   clr        : synchronous clear, takes priority over inc
//   count      : current value
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/alu_result_buffer.sv
// Registered output stage behind the ALU: a DEPTH-entry FIFO of
// {result, zero, neg} with valid/ready on both sides, a zero-flag
// consistency check and saturating retirement statistics.
//   in_valid/in_ready/in_result/in_zero : upstream push interface
//   out_valid/out_ready/out_result/out_zero/out_neg : consumer pop interface
//   fill       : occupied entries
//   stat_clr   : synchronous clear of stat_total, stat_zero, err_flag
//   stat_total : retired results (saturating)
//   stat_zero  : retired results with zero flag set (saturating)
//   err_flag   : sticky, set when a pushed zero flag disagrees with its result
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_result,
  input  logic                       in_zero,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_result,
  output logic                       out_zero,
  output logic                       out_neg,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  input  logic                       stat_clr,
  output logic [CNT_W-1:0]           stat_total,
  output logic [CNT_W-1:0]           stat_zero,
  output logic                       err_flag
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             neg;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              err_q, err_d;

  logic   push, pop, mismatch;
  entry_t head;

  assign in_ready  = (fill_q != FILL_W'(DEPTH));
  assign out_valid = (fill_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign mismatch  = in_zero != (in_result == '0);
  assign head      = mem_q[rd_ptr_q];

  // Head fields are gated so stale storage never leaks out when empty.
  assign out_result = out_valid ? head.result : '0;
  assign out_zero   = out_valid & head.zero;
  assign out_neg    = out_valid & head.neg;
  assign fill       = fill_q;
  assign err_flag   = err_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    err_d    = err_q;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      fill_d = fill_q + FILL_W'(1);
    else if (pop && !push) fill_d = fill_q - FILL_W'(1);
    if (stat_clr)              err_d = 1'b0;
    else if (push && mismatch) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: an empty buffer hides every entry.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{result: in_result, zero: in_zero,
                           neg: in_result[WIDTH-1]};
    end
  end

  sat_counter #(.W(CNT_W)) u_total (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop),
    .clr   (stat_clr),
    .count (stat_total)
  );

  sat_counter #(.W(CNT_W)) u_zero (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop & head.zero),
    .clr   (stat_clr),
    .count (stat_zero)
  );

endmodule

// File: tb/tb_alu_result_buffer.sv
module tb_alu_result_buffer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_result = '0;
  logic        in_zero = 1'b0;
  logic        out_ready = 1'b0;
  logic        stat_clr = 1'b0;

  logic        in_ready, out_valid, out_zero, out_neg, err_flag;
  logic [31:0] out_result;
  logic [2:0]  fill;
  logic [15:0] stat_total, stat_zero;

  logic        s_in_ready, s_out_valid, s_out_zero, s_out_neg, s_err_flag;
  logic [31:0] s_out_result;
  logic [2:0]  s_fill;
  logic [1:0]  s_stat_total, s_stat_zero;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  alu_result_buffer #(.WIDTH(32), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_neg(out_neg), .fill(fill),
    .stat_clr(stat_clr), .stat_total(stat_total), .stat_zero(stat_zero),
    .err_flag(err_flag)
  );

  // Same stimulus, 2-bit counters: exercises saturation.
  alu_result_buffer #(.WIDTH(32), .DEPTH(4), .CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_result(in_result), .in_zero(in_zero),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_result(s_out_result),
    .out_zero(s_out_zero), .out_neg(s_out_neg), .fill(s_fill),
    .stat_clr(stat_clr), .stat_total(s_stat_total), .stat_zero(s_stat_zero),
    .err_flag(s_err_flag)
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [31:0] res, input logic iz,
                      input logic ordy, input logic clr);
    in_valid  = iv;
    in_result = res;
    in_zero   = iz;
    out_ready = ordy;
    stat_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] ires;
    logic        iz;
    logic        ordy;
    logic        clr;
    logic        ev;
    logic [31:0] eres;
    logic        ez;
    logic        en;
    logic [2:0]  efill;
    logic        erdy;
    logic [15:0] etot;
    logic [15:0] ezc;
    logic        eerr;
    logic [1:0]  esm;
  } vec_t;

  vec_t vt [20];

  initial begin
    //          iv ires          iz ordy clr | ev eres          ez en fill rdy tot zc err small
    vt[0]  = '{1, ALU_ONES,     0, 0, 0,    1, ALU_ONES,     0, 1, 1, 1, 0, 0, 0, 0};
    vt[1]  = '{0, 32'h0,        0, 1, 0,    0, 32'h0,        0, 0, 0, 1, 1, 0, 0, 1};
    vt[2]  = '{1, 32'h1,        0, 0, 0,    1, 32'h1,        0, 0, 1, 1, 1, 0, 0, 1};
    vt[3]  = '{1, 32'h0,        1, 0, 0,    1, 32'h1,        0, 0, 2, 1, 1, 0, 0, 1};
    vt[4]  = '{1, 32'h80000000, 0, 0, 0,    1, 32'h1,        0, 0, 3, 1, 1, 0, 0, 1};
    vt[5]  = '{1, 32'h7,        0, 0, 0,    1, 32'h1,        0, 0, 4, 0, 1, 0, 0, 1};
    vt[6]  = '{1, 32'h55,       0, 0, 0,    1, 32'h1,        0, 0, 4, 0, 1, 0, 0, 1};
    vt[7]  = '{0, 32'h0,        0, 1, 0,    1, 32'h0,        1, 0, 3, 1, 2, 0, 0, 2};
    vt[8]  = '{0, 32'h0,        0, 1, 0,    1, 32'h80000000, 0, 1, 2, 1, 3, 1, 0, 3};
    vt[9]  = '{0, 32'h0,        0, 1, 0,    1, 32'h7,        0, 0, 1, 1, 4, 1, 0, 3};
    vt[10] = '{0, 32'h0,        0, 1, 0,    0, 32'h0,        0, 0, 0, 1, 5, 1, 0, 3};
    vt[11] = '{0, 32'h0,        0, 1, 0,    0, 32'h0,        0, 0, 0, 1, 5, 1, 0, 3};
    vt[12] = '{1, 32'h0,        0, 0, 0,    1, 32'h0,        0, 0, 1, 1, 5, 1, 1, 3};
    vt[13] = '{0, 32'h0,        0, 0, 0,    1, 32'h0,        0, 0, 1, 1, 5, 1, 1, 3};
    vt[14] = '{0, 32'h0,        0, 1, 1,    0, 32'h0,        0, 0, 0, 1, 0, 0, 0, 0};
    vt[15] = '{1, 32'h5,        1, 0, 0,    1, 32'h5,        1, 0, 1, 1, 0, 0, 1, 0};
    vt[16] = '{0, 32'h0,        0, 0, 1,    1, 32'h5,        1, 0, 1, 1, 0, 0, 0, 0};
    vt[17] = '{1, 32'h0,        0, 0, 1,    1, 32'h5,        1, 0, 2, 1, 0, 0, 0, 0};
    vt[18] = '{0, 32'h0,        0, 1, 0,    1, 32'h0,        0, 0, 1, 1, 1, 1, 0, 1};
    vt[19] = '{0, 32'h0,        0, 1, 0,    0, 32'h0,        0, 0, 0, 1, 2, 1, 0, 2};

    // Reset state while rst_n is held low.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 0, 32'(out_valid), 32'd0);
    chk("rst_in_ready",  0, 32'(in_ready),  32'd1);
    chk("rst_fill",      0, 32'(fill),      32'd0);
    chk("rst_out_result",0, out_result,     32'd0);
    chk("rst_total",     0, 32'(stat_total),32'd0);
    chk("rst_err",       0, 32'(err_flag),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      step(vt[i].iv, vt[i].ires, vt[i].iz, vt[i].ordy, vt[i].clr);
      chk("out_valid",  i, 32'(out_valid),    32'(vt[i].ev));
      chk("out_result", i, out_result,        vt[i].eres);
      chk("out_zero",   i, 32'(out_zero),     32'(vt[i].ez));
      chk("out_neg",    i, 32'(out_neg),      32'(vt[i].en));
      chk("fill",       i, 32'(fill),         32'(vt[i].efill));
      chk("in_ready",   i, 32'(in_ready),     32'(vt[i].erdy));
      chk("stat_total", i, 32'(stat_total),   32'(vt[i].etot));
      chk("stat_zero",  i, 32'(stat_zero),    32'(vt[i].ezc));
      chk("err_flag",   i, 32'(err_flag),     32'(vt[i].eerr));
      chk("small_total",i, 32'(s_stat_total), 32'(vt[i].esm));
    end

    // Steady stream: one push and one pop per cycle after the first.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b1, 1'b0);
      chk("stream_fill",   i, 32'(fill),       32'd1);
      chk("stream_head",   i, out_result,      32'h100 + 32'(i));
      chk("stream_total",  i, 32'(stat_total), 32'd2 + 32'(i));
    end
    chk("stream_small", 0, 32'(s_stat_total), 32'd3);
    chk("stream_err",   0, 32'(err_flag),     32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("stream_drain_fill",  0, 32'(fill),       32'd0);
    chk("stream_drain_total", 0, 32'(stat_total), 32'd12);

    // Asynchronous reset with three entries buffered.
    step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("pre_rst_fill", 0, 32'(fill),     32'd3);
    chk("pre_rst_err",  0, 32'(err_flag), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 0, 32'(out_valid),  32'd0);
    chk("arst_fill",      0, 32'(fill),       32'd0);
    chk("arst_total",     0, 32'(stat_total), 32'd0);
    chk("arst_zero",      0, 32'(stat_zero),  32'd0);
    chk("arst_err",       0, 32'(err_flag),   32'd0);
    chk("arst_in_ready",  0, 32'(in_ready),   32'd1);
    chk("arst_result",    0, out_result,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h33, 1'b0, 1'b0, 1'b0);
    chk("post_rst_head", 0, out_result, 32'h33);
    chk("post_rst_fill", 0, 32'(fill), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
